// File: rtl/trg_pkg.sv
// trg_pkg -- shared definitions for the trigger receiver.
//   Command codes handed to the ROC/TBM sequencer, bit positions on the
//   5-bit trigger bus, and helpers for priority decoding and bit counting.
package trg_pkg;

  typedef enum logic [2:0] {
    CMD_NONE    = 3'd0,
    CMD_SYNC    = 3'd1,
    CMD_TRIG    = 3'd2,
    CMD_CAL     = 3'd3,
    CMD_RES_ROC = 3'd4,
    CMD_RES_TBM = 3'd5
  } trg_cmd_e;

  localparam int TRG_BUS_W       = 5;
  localparam int TRG_BIT_SYNC    = 0;
  localparam int TRG_BIT_TRIG    = 1;
  localparam int TRG_BIT_CAL     = 2;
  localparam int TRG_BIT_RES_ROC = 3;
  localparam int TRG_BIT_RES_TBM = 4;
  localparam int TS_W            = 32;
  localparam int CMD_W           = 3;

  // Highest-priority bus bit wins: reset_tbm > reset_roc > cal > trigger > sync-mark.
  function automatic trg_cmd_e trg_prio_encode(input logic [TRG_BUS_W-1:0] bus);
    trg_cmd_e cmd;
    if (bus[TRG_BIT_RES_TBM]) begin
      cmd = CMD_RES_TBM;
    end else if (bus[TRG_BIT_RES_ROC]) begin
      cmd = CMD_RES_ROC;
    end else if (bus[TRG_BIT_CAL]) begin
      cmd = CMD_CAL;
    end else if (bus[TRG_BIT_TRIG]) begin
      cmd = CMD_TRIG;
    end else if (bus[TRG_BIT_SYNC]) begin
      cmd = CMD_SYNC;
    end else begin
      cmd = CMD_NONE;
    end
    return cmd;
  endfunction

  // Number of bus bits set on one tick (0..5).
  function automatic logic [2:0] trg_bit_count(input logic [TRG_BUS_W-1:0] bus);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < TRG_BUS_W; i++) begin
      n = n + {2'b00, bus[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/trg_fifo.sv
// trg_fifo -- synchronous DEPTH-entry FIFO with a registered head.
//   clk, reset (async, active-high)
//   push/wdata    : write request; ignored while full (caller counts the drop)
//   pop_ready     : consumer accepts the head when out_valid is high
//   full          : occupancy == DEPTH, evaluated before any same-cycle pop
//   out_valid/out_data : registered head; out_data holds its last value when empty
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module trg_fifo
  import trg_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = CMD_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop_ready,
  output logic          full,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic          do_push, do_pop;
  logic [AW-1:0] wr_idx, rd_nxt_idx;

  // Next-state: pointers, storage and the head value that will be visible after this clk.
  always_comb begin
    full       = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    do_push    = push && !full;
    do_pop     = valid_q && pop_ready;
    wr_ptr_d   = wr_ptr_q + PW'(do_push);
    rd_ptr_d   = rd_ptr_q + PW'(do_pop);
    wr_idx     = wr_ptr_q[AW-1:0];
    rd_nxt_idx = rd_ptr_d[AW-1:0];
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (do_push) begin
      mem_d[wr_idx] = wdata;
    end else begin
      mem_d[wr_idx] = mem_q[wr_idx];
    end
    valid_d = (wr_ptr_d != rd_ptr_d);
    // The head is looked up in the post-write image so a push into an empty FIFO shows next clk.
    if (valid_d) begin
      data_d = mem_d[rd_nxt_idx];
    end else begin
      data_d = data_q;
    end
  end

  // State register; reset discards all contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      valid_q  <= 1'b0;
      data_q   <= {DW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DW{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/trigger_receiver.sv
// trigger_receiver -- consumer end of the 5-bit trigger bus.
//   clk, reset (async, active-high)
//   sync       : clock enable for bus sampling, deadtime and timestamp counting
//   enable     : 0 ignores all bus events (not counted)
//   trg_in     : [0] sync-mark [1] trigger [2] cal [3] reset_roc [4] reset_tbm
//   deadtime   : sync ticks after an accepted trigger during which triggers are dropped
//   clear_cnt  : synchronous clear of trg_count/drop_count (wins over increments)
//   out_valid/out_ready/out_cmd/out_ts : command stream to the sequencer
//   trg_count  : pushed commands, wraps; drop_count : dropped events, saturates
// Optional build macro TRG_TIMESTAMP_EN adds a 32-bit sync-tick timestamp stored
// with each entry; without it out_ts is tied to zero.
module trigger_receiver
  import trg_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int DT_WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sync,
  input  logic                enable,
  input  logic [4:0]          trg_in,
  input  logic [DT_WIDTH-1:0] deadtime,
  input  logic                clear_cnt,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2:0]          out_cmd,
  output logic [31:0]         out_ts,
  output logic [31:0]         trg_count,
  output logic [15:0]         drop_count
);

`ifdef TRG_TIMESTAMP_EN
  localparam int FIFO_W = TS_W + CMD_W;
`else
  localparam int FIFO_W = CMD_W;
`endif

  logic                tick_evt;
  trg_cmd_e            tick_cmd;
  logic [2:0]          lower_bits;
  logic                trig_gated;
  logic                fifo_full;
  logic                push_req;
  logic                head_drop;
  logic [3:0]          drop_inc;
  logic [16:0]         drop_sum;
  logic [FIFO_W-1:0]   fifo_wdata;
  logic [FIFO_W-1:0]   fifo_rdata;
  logic                fifo_valid;

  logic [DT_WIDTH-1:0] dt_cnt_q, dt_cnt_d;
  logic [31:0]         trg_count_q, trg_count_d;
  logic [15:0]         drop_count_q, drop_count_d;
`ifdef TRG_TIMESTAMP_EN
  logic [31:0]         ts_q, ts_d;
`endif

  // Tick decode: pick one command, decide whether it is pushed or dropped, and tally drops.
  always_comb begin
    tick_evt = sync && enable && (trg_in != 5'd0);
    tick_cmd = trg_prio_encode(trg_in);
    if (tick_evt) begin
      lower_bits = trg_bit_count(trg_in) - 3'd1;
    end else begin
      lower_bits = 3'd0;
    end
    trig_gated = (tick_cmd == CMD_TRIG) && (dt_cnt_q != {DT_WIDTH{1'b0}});
    // Fullness is the pre-pop value, so a full FIFO drops even if it is being drained this clk.
    push_req   = tick_evt && !trig_gated && !fifo_full;
    head_drop  = tick_evt && (trig_gated || fifo_full);
    drop_inc   = {1'b0, lower_bits} + {3'b000, head_drop};
    drop_sum   = {1'b0, drop_count_q} + {13'd0, drop_inc};
`ifdef TRG_TIMESTAMP_EN
    fifo_wdata = {ts_q, tick_cmd};
`else
    fifo_wdata = tick_cmd;
`endif
  end

  // Deadtime and statistics next-state.
  always_comb begin
    // Only a trigger that actually enters the FIFO arms the deadtime window.
    if (push_req && (tick_cmd == CMD_TRIG)) begin
      dt_cnt_d = deadtime;
    end else if (sync && (dt_cnt_q != {DT_WIDTH{1'b0}})) begin
      dt_cnt_d = dt_cnt_q - {{(DT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      dt_cnt_d = dt_cnt_q;
    end

    if (clear_cnt) begin
      trg_count_d = 32'd0;
    end else if (push_req) begin
      trg_count_d = trg_count_q + 32'd1;
    end else begin
      trg_count_d = trg_count_q;
    end

    if (clear_cnt) begin
      drop_count_d = 16'd0;
    end else if (drop_sum[16]) begin
      drop_count_d = 16'hFFFF;
    end else begin
      drop_count_d = drop_sum[15:0];
    end
  end

`ifdef TRG_TIMESTAMP_EN
  // Timestamp advances once per sync tick and wraps.
  always_comb begin
    if (sync) begin
      ts_d = ts_q + 32'd1;
    end else begin
      ts_d = ts_q;
    end
  end

  // Timestamp register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_q <= 32'd0;
    end else begin
      ts_q <= ts_d;
    end
  end
`endif

  // Deadtime and statistics registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dt_cnt_q     <= {DT_WIDTH{1'b0}};
      trg_count_q  <= 32'd0;
      drop_count_q <= 16'd0;
    end else begin
      dt_cnt_q     <= dt_cnt_d;
      trg_count_q  <= trg_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  trg_fifo #(
    .DEPTH (DEPTH),
    .DW    (FIFO_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_req),
    .wdata     (fifo_wdata),
    .pop_ready (out_ready),
    .full      (fifo_full),
    .out_valid (fifo_valid),
    .out_data  (fifo_rdata)
  );

  assign out_valid  = fifo_valid;
  assign out_cmd    = fifo_rdata[CMD_W-1:0];
`ifdef TRG_TIMESTAMP_EN
  assign out_ts     = fifo_rdata[FIFO_W-1:CMD_W];
`else
  assign out_ts     = 32'd0;
`endif
  assign trg_count  = trg_count_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_trigger_receiver.sv
// Bench for trigger_receiver: directed table, hand sequences for the multi-cycle
// corners, and randomized traffic against a queue-based reference model.
module tb_trigger_receiver;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        sync;
  logic        enable;
  logic [4:0]  trg_in;
  logic [15:0] deadtime;
  logic        clear_cnt;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_cmd;
  logic [31:0] out_ts;
  logic [31:0] trg_count;
  logic [15:0] drop_count;

  int n_vec = 0;
  int n_err = 0;

  trigger_receiver #(.DEPTH(DEPTH), .DT_WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .sync       (sync),
    .enable     (enable),
    .trg_in     (trg_in),
    .deadtime   (deadtime),
    .clear_cnt  (clear_cnt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_cmd    (out_cmd),
    .out_ts     (out_ts),
    .trg_count  (trg_count),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [2:0]  cmd;
    logic [31:0] ts;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_trg;
  logic [31:0] m_ts;
  logic [31:0] m_out_ts;
  logic [2:0]  m_cmd;
  logic        m_valid;
  int          m_drop;
  int          m_dt;

  task automatic model_reset();
    mq.delete();
    m_trg = 32'd0; m_ts = 32'd0; m_out_ts = 32'd0;
    m_cmd = 3'd0; m_valid = 1'b0; m_drop = 0; m_dt = 0;
  endtask

  // One clk of behaviour from the current inputs; afterwards the model holds post-edge values.
  task automatic model_step();
    int   drops;
    int   code;
    bit   pushed;
    bit   was_full;
    bit   popping;
    ent_t e;
    drops = 0; code = 0; pushed = 1'b0;
    was_full = (mq.size() == DEPTH);
    popping  = (mq.size() != 0) && out_ready;
    if (sync && enable && trg_in != 5'd0) begin
      for (int b = 0; b < 5; b++) if (trg_in[b]) code = b + 1;  // highest bit wins
      drops = $countones(trg_in) - 1;
      if (code == 2 && m_dt > 0) drops++;
      else if (was_full) drops++;
      else pushed = 1'b1;
    end
    if (pushed && code == 2) m_dt = int'(deadtime);
    else if (sync && m_dt > 0) m_dt--;
    if (popping) void'(mq.pop_front());
    if (pushed) begin
      e.cmd = code[2:0];
      e.ts  = m_ts;
      mq.push_back(e);
    end
    if (clear_cnt) begin
      m_trg = 32'd0;
      m_drop = 0;
    end else begin
      if (pushed) m_trg = m_trg + 32'd1;
      m_drop = (m_drop + drops > 65535) ? 65535 : m_drop + drops;
    end
    if (sync) m_ts = m_ts + 32'd1;
    m_valid = (mq.size() != 0);
    if (m_valid) begin
      m_cmd = mq[0].cmd;
      m_out_ts = mq[0].ts;
    end
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_ts(input logic [31:0] ts);
`ifdef TRG_TIMESTAMP_EN
    return ts;
`else
    return 32'd0 & ts;
`endif
  endfunction

  task automatic cmp_model(input string tag);
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, m_valid});
    chk({tag, ".cmd"}, {29'd0, out_cmd}, {29'd0, m_cmd});
    chk({tag, ".ts"}, out_ts, exp_ts(m_out_ts));
    chk({tag, ".trg_count"}, trg_count, m_trg);
    chk({tag, ".drop_count"}, {16'd0, drop_count}, 32'(m_drop));
  endtask

  // Apply inputs, advance the model, take one clk and settle 1 time unit past the edge.
  task automatic cyc(input logic s, input logic e, input logic [4:0] t, input logic r, input logic c);
    sync = s; enable = e; trg_in = t; out_ready = r; clear_cnt = c;
    model_step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        s, e;
    logic [4:0]  t;
    logic        r, c;
    logic        ev;
    logic [2:0]  ecmd;
    logic [31:0] etrg;
    logic [15:0] edrop;
  } vec_t;

  vec_t tbl[15];
  int   occ;

  initial begin
    // deadtime = 3 throughout the table
    tbl[0]  = '{1'b1, 1'b1, 5'b00010, 1'b0, 1'b0, 1'b1, 3'd2, 32'd1, 16'd0};
    tbl[1]  = '{1'b1, 1'b1, 5'b00010, 1'b0, 1'b0, 1'b1, 3'd2, 32'd1, 16'd1};
    tbl[2]  = '{1'b1, 1'b1, 5'b00010, 1'b0, 1'b0, 1'b1, 3'd2, 32'd1, 16'd2};
    tbl[3]  = '{1'b1, 1'b1, 5'b00010, 1'b0, 1'b0, 1'b1, 3'd2, 32'd1, 16'd3};
    tbl[4]  = '{1'b1, 1'b1, 5'b00010, 1'b0, 1'b0, 1'b1, 3'd2, 32'd2, 16'd3};
    tbl[5]  = '{1'b0, 1'b1, 5'b00000, 1'b1, 1'b0, 1'b1, 3'd2, 32'd2, 16'd3};
    tbl[6]  = '{1'b0, 1'b1, 5'b00000, 1'b1, 1'b0, 1'b0, 3'd2, 32'd2, 16'd3};
    tbl[7]  = '{1'b1, 1'b1, 5'b11010, 1'b0, 1'b0, 1'b1, 3'd5, 32'd3, 16'd5};
    tbl[8]  = '{1'b1, 1'b0, 5'b11111, 1'b0, 1'b0, 1'b1, 3'd5, 32'd3, 16'd5};
    tbl[9]  = '{1'b0, 1'b1, 5'b00000, 1'b1, 1'b0, 1'b0, 3'd5, 32'd3, 16'd5};
    tbl[10] = '{1'b1, 1'b1, 5'b00001, 1'b0, 1'b1, 1'b1, 3'd1, 32'd0, 16'd0};
    tbl[11] = '{1'b1, 1'b1, 5'b00100, 1'b1, 1'b0, 1'b1, 3'd3, 32'd1, 16'd0};
    tbl[12] = '{1'b0, 1'b1, 5'b00000, 1'b1, 1'b0, 1'b0, 3'd3, 32'd1, 16'd0};
    tbl[13] = '{1'b1, 1'b1, 5'b00010, 1'b0, 1'b0, 1'b1, 3'd2, 32'd2, 16'd0};
    tbl[14] = '{1'b1, 1'b1, 5'b00010, 1'b0, 1'b0, 1'b1, 3'd2, 32'd2, 16'd1};

    reset = 1'b1; sync = 1'b0; enable = 1'b0; trg_in = 5'd0;
    deadtime = 16'd3; clear_cnt = 1'b0; out_ready = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk("rst.valid", {31'd0, out_valid}, 32'd0);
    chk("rst.cmd", {29'd0, out_cmd}, 32'd0);
    chk("rst.ts", out_ts, 32'd0);
    chk("rst.trg_count", trg_count, 32'd0);
    chk("rst.drop_count", {16'd0, drop_count}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].s, tbl[i].e, tbl[i].t, tbl[i].r, tbl[i].c);
      chk($sformatf("tbl%0d.valid", i), {31'd0, out_valid}, {31'd0, tbl[i].ev});
      chk($sformatf("tbl%0d.cmd", i), {29'd0, out_cmd}, {29'd0, tbl[i].ecmd});
      chk($sformatf("tbl%0d.trg", i), trg_count, tbl[i].etrg);
      chk($sformatf("tbl%0d.drop", i), {16'd0, drop_count}, {16'd0, tbl[i].edrop});
    end

    // FIFO fill with ready low, then drain in order
    cyc(1'b0, 1'b1, 5'd0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 5'd0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 5'd0, 1'b0, 1'b1);
    deadtime = 16'd0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b1, 5'b00010, 1'b0, 1'b0);
      cmp_model("fill");
    end
    chk("fill.trg_count", trg_count, 32'd4);
    chk("fill.drop_count", {16'd0, drop_count}, 32'd2);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 5'd0, 1'b1, 1'b0);
      cmp_model("drain");
    end
    chk("drain.valid_low", {31'd0, out_valid}, 32'd0);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 5'b00010, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 5'b00010, 1'b1, 1'b0);
    cmp_model("fullpp");
    chk("fullpp.drop_count", {16'd0, drop_count}, 32'd3);
    occ = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) occ++;
      cyc(1'b0, 1'b1, 5'd0, 1'b1, 1'b0);
    end
    chk("fullpp.occupancy", 32'(occ), 32'd3);

    // Clear with a same-clk accepted event, then drop_count saturation
    cyc(1'b1, 1'b1, 5'b00100, 1'b0, 1'b1);
    chk("clr.trg_count", trg_count, 32'd0);
    chk("clr.drop_count", {16'd0, drop_count}, 32'd0);
    chk("clr.valid", {31'd0, out_valid}, 32'd1);
    chk("clr.cmd", {29'd0, out_cmd}, 32'd3);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 5'b00100, 1'b0, 1'b0);
    for (int i = 0; i < 13107; i++) cyc(1'b1, 1'b1, 5'b11111, 1'b0, 1'b0);
    chk("sat.reach", {16'd0, drop_count}, 32'h0000FFFF);
    cyc(1'b1, 1'b1, 5'b11111, 1'b0, 1'b0);
    chk("sat.hold", {16'd0, drop_count}, 32'h0000FFFF);
    chk("sat.trg_count", trg_count, 32'd3);
    cmp_model("sat");

    // Reset mid-operation with queued entries and pending deadtime
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 5'd0, 1'b1, 1'b0);
    deadtime = 16'd7;
    cyc(1'b1, 1'b1, 5'b00100, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 5'b00100, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 5'b00010, 1'b0, 1'b0);
    cmp_model("prerst");
    sync = 1'b0; trg_in = 5'd0;
    #2 reset = 1'b1;
    #1;
    chk("midrst.valid", {31'd0, out_valid}, 32'd0);
    chk("midrst.trg_count", trg_count, 32'd0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 5'b00010, 1'b0, 1'b0);
    chk("postrst.valid", {31'd0, out_valid}, 32'd1);
    chk("postrst.cmd", {29'd0, out_cmd}, 32'd2);
    chk("postrst.trg_count", trg_count, 32'd1);
`ifdef TRG_TIMESTAMP_EN
    chk("postrst.ts", out_ts, 32'd9);
`else
    chk("postrst.ts", out_ts, 32'd0);
`endif
    cmp_model("postrst");

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      logic       s, e, r, c;
      logic [4:0] t;
      if ($urandom_range(0, 39) == 0) deadtime = 16'($urandom_range(0, 6));
      s = ($urandom_range(0, 3) != 0);
      e = ($urandom_range(0, 9) != 0);
      t = 5'($urandom);
      if ($urandom_range(0, 2) == 0) t = 5'b00010;
      r = ($urandom_range(0, 2) == 0);
      c = ($urandom_range(0, 80) == 0);
      cyc(s, e, t, r, c);
      cmp_model("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
